// File: rtl/vision_pkg.sv
// Shared definitions for the vision output path: source indices, the
// stream-controller state type and the nominal image geometry.
package vision_pkg;

  // Tap indices as seen by the output scheduler
  localparam int SRC_UNPACK = 0;
  localparam int SRC_GX     = 1;
  localparam int SRC_GY     = 2;
  localparam int SRC_MAG    = 3;

  // Nominal camera frame geometry
  localparam int IMAGE_W = 320;
  localparam int IMAGE_H = 240;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/frame_counter.sv
// Column/row position counter for one frame. Advances on every accepted
// beat, wraps the column at end of line and the row at end of frame, and
// flags the beat that completes the frame.
module frame_counter
  import vision_pkg::*;
#(
  parameter int linewidth_px_p = IMAGE_W,
  parameter int lines_p        = IMAGE_H
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic accept_i,
  output logic last_o
);

  // A single-line frame still needs a 1-bit row register
  localparam int COL_W = (linewidth_px_p > 1) ? $clog2(linewidth_px_p) : 1;
  localparam int ROW_W = (lines_p > 1) ? $clog2(lines_p) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(linewidth_px_p - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(lines_p - 1);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             col_wrap;
  logic             row_wrap;

  assign col_wrap = (col_q == COL_LAST);
  assign row_wrap = (row_q == ROW_LAST);

  // Next position: hold unless a beat is accepted, never count past the terminals
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept_i) begin
      if (col_wrap) begin
        col_d = '0;
        row_d = row_wrap ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Position registers, cleared immediately by reset so an aborted frame restarts at 0,0
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign last_o = col_wrap && row_wrap;

endmodule

// File: rtl/frame_stream_ctrl.sv
// Frame-aware output scheduler. Latches one source per frame from the
// synchronized button request, forwards that source to the packer with
// zero-latency handshaking, drains every other tap, and returns to IDLE
// after exactly linewidth_px_p * lines_p accepted beats.
module frame_stream_ctrl
  import vision_pkg::*;
#(
  parameter int num_src_p      = 4,
  parameter int width_p        = 1,
  parameter int linewidth_px_p = IMAGE_W,
  parameter int lines_p        = IMAGE_H,
  parameter int default_src_p  = SRC_MAG
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [num_src_p-2:0]           mode_i,
  input  logic [num_src_p-1:0]           valid_i,
  input  logic [num_src_p*width_p-1:0]   data_i,
  output logic [num_src_p-1:0]           ready_o,
  output logic                           valid_o,
  output logic [width_p-1:0]             data_o,
  input  logic                           ready_i,
  output logic [$clog2(num_src_p)-1:0]   sel_o,
  output logic                           busy_o,
  output logic                           frame_done_o
);

  localparam int SEL_W = $clog2(num_src_p);
  localparam int NM    = num_src_p - 1;

  // One-hot request picks that source; idle buttons or chords fall back to the default
  function automatic logic [SEL_W-1:0] decode_mode(input logic [NM-1:0] m);
    logic [SEL_W-1:0] idx;
    int               ones;
    idx  = SEL_W'(default_src_p);
    ones = 0;
    for (int k = 0; k < NM; k++) begin
      if (m[k]) ones++;
    end
    if (ones == 1) begin
      for (int k = 0; k < NM; k++) begin
        if (m[k]) idx = SEL_W'(k);
      end
    end
    return idx;
  endfunction

  logic [NM-1:0]    mode_s1_q;
  logic [NM-1:0]    mode_s2_q;
  logic [SEL_W-1:0] mode_dec;
  ctrl_state_e      state_q;
  logic [SEL_W-1:0] sel_q;
  logic             frame_done_q;
  logic             sel_valid;
  logic [width_p-1:0] sel_data;
  logic             dec_valid;
  logic             streaming;
  logic             accept;
  logic             last_beat;

  // Two-flop synchronizer for the asynchronous button levels
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      mode_s1_q <= '0;
      mode_s2_q <= '0;
    end else begin
      mode_s1_q <= mode_i;
      mode_s2_q <= mode_s1_q;
    end
  end

  assign mode_dec  = decode_mode(mode_s2_q);
  assign streaming = (state_q == STREAM);

  // Source muxes: latched source for the output path, decoded source for the start trigger
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    dec_valid = 1'b0;
    for (int k = 0; k < num_src_p; k++) begin
      if (sel_q == SEL_W'(k)) begin
        sel_valid = valid_i[k];
        sel_data  = data_i[k*width_p +: width_p];
      end
      if (mode_dec == SEL_W'(k)) begin
        dec_valid = valid_i[k];
      end
    end
  end

  // Drain every tap except the one being streamed, which follows the packer's ready
  always_comb begin
    ready_o = '1;
    if (streaming) begin
      for (int k = 0; k < num_src_p; k++) begin
        if (sel_q == SEL_W'(k)) ready_o[k] = ready_i;
      end
    end
  end

  // valid_o is gated only by state, never by ready_i
  assign valid_o = streaming && sel_valid;
  assign data_o  = sel_data;
  assign accept  = valid_o && ready_i;

  frame_counter #(
    .linewidth_px_p (linewidth_px_p),
    .lines_p        (lines_p)
  ) u_frame_counter (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .accept_i (accept),
    .last_o   (last_beat)
  );

  // Frame FSM: track the request while idle, freeze the source for a whole frame
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q      <= IDLE;
      sel_q        <= SEL_W'(default_src_p);
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          sel_q <= mode_dec;
          if (dec_valid) state_q <= STREAM;
        end
        STREAM: begin
          if (accept && last_beat) begin
            state_q      <= IDLE;
            frame_done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sel_o        = sel_q;
  assign busy_o       = streaming;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_frame_stream_ctrl.sv
// Scoreboard bench for frame_stream_ctrl with a 4x2 frame: stimulus pushes
// the expected pixel sequence per frame, a negedge monitor pops and compares
// every accepted beat and the frame_done pulse that must follow the last one.
module tb_frame_stream_ctrl;

  localparam int NS = 4;
  localparam int WP = 1;
  localparam int LW = 4;
  localparam int LH = 2;

  logic          clk_i = 1'b0;
  logic          rst_n;
  logic [NS-2:0] mode_i;
  logic [NS-1:0] valid_i;
  logic [NS*WP-1:0] data_i;
  logic [NS-1:0] ready_o;
  logic          valid_o;
  logic [WP-1:0] data_o;
  logic          ready_i;
  logic [1:0]    sel_o;
  logic          busy_o;
  logic          frame_done_o;

  always #5 clk_i = ~clk_i;

  frame_stream_ctrl #(
    .num_src_p      (NS),
    .width_p        (WP),
    .linewidth_px_p (LW),
    .lines_p        (LH),
    .default_src_p  (3)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (rst_n),
    .mode_i       (mode_i),
    .valid_i      (valid_i),
    .data_i       (data_i),
    .ready_o      (ready_o),
    .valid_o      (valid_o),
    .data_o       (data_o),
    .ready_i      (ready_i),
    .sel_o        (sel_o),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o)
  );

  // Per-source 8-beat pixel patterns, beat n is bit n
  // src0: 1,1,0,0,1,1,0,0  src1: 1,0,1,1,0,0,1,0  src2: 0,1,1,0,1,0,0,1  src3: 1,0,0,1,1,1,0,1
  function automatic logic pat_bit(input int s, input int n);
    logic [7:0] p;
    case (s)
      0:       p = 8'h33;
      1:       p = 8'h4D;
      2:       p = 8'h96;
      default: p = 8'hB9;
    endcase
    return p[n];
  endfunction

  // Sources present the next pixel of their pattern once the packer takes a beat
  logic [2:0] bidx;
  always @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) bidx <= 3'd0;
    else if (valid_o && ready_i) bidx <= bidx + 3'd1;
  end
  assign data_i = {pat_bit(3, int'(bidx)), pat_bit(2, int'(bidx)),
                   pat_bit(1, int'(bidx)), pat_bit(0, int'(bidx))};

  int   checks = 0;
  int   errors = 0;
  logic exp_q[$];

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input int s);
    for (int n = 0; n < LW*LH; n++) exp_q.push_back(pat_bit(s, n));
  endtask

  // Monitor
  int   mon_beats = 0;
  logic done_pending = 1'b0;
  logic held_v = 1'b0;
  logic held_d = 1'b0;
  logic mon_e;
  always @(negedge clk_i) begin
    if (!rst_n) begin
      mon_beats    = 0;
      done_pending = 1'b0;
      held_v       = 1'b0;
      check1("done_in_reset", frame_done_o, 1'b0);
    end else begin
      if (done_pending || frame_done_o) check1("frame_done", frame_done_o, done_pending);
      done_pending = 1'b0;
      if (held_v) begin
        check1("stall_valid", valid_o, 1'b1);
        check1("stall_data", data_o, held_d);
      end
      held_v = valid_o && !ready_i;
      held_d = data_o[0];
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data %0b, expected no beat at %0t", data_o, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check1("beat_data", data_o, mon_e);
        end
        mon_beats++;
        if (mon_beats == LW*LH) begin
          mon_beats    = 0;
          done_pending = 1'b1;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic start_frame(input int s);
    push_frame(s);
    valid_i = '1;
    tick(1);
    check1("start_busy", busy_o, 1'b1);
    check1("start_sel", sel_o, s);
  endtask

  task automatic wait_beats(input int n);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < 200) begin
      @(negedge clk_i);
      if (valid_o && ready_i) got++;
      tick(1);
      cyc++;
    end
    check1("wait_beats", got, n);
  endtask

  task automatic wait_done(input bit drop, input bit toggle, input int s);
    bit got = 1'b0;
    int cyc = 0;
    while (!got && cyc < 100) begin
      tick(1);
      cyc++;
      if (frame_done_o) got = 1'b1;
      else if (toggle && busy_o) begin
        check1("ready_sel", ready_o[s], ready_i);
        check1("ready_others", ready_o | (4'b0001 << s), 4'hF);
        ready_i = ~ready_i;
      end
    end
    if (drop) valid_i = '0;
    ready_i = 1'b1;
    check1("frame_done_seen", got, 1'b1);
    check1("idle_after_frame", busy_o, 1'b0);
  endtask

  initial begin
    rst_n   = 1'b0;
    mode_i  = 3'b000;
    valid_i = '0;
    ready_i = 1'b1;
    tick(3);
    check1("rst_sel", sel_o, 2'd3);
    check1("rst_busy", busy_o, 1'b0);
    check1("rst_done", frame_done_o, 1'b0);
    check1("rst_valid", valid_o, 1'b0);
    check1("rst_ready", ready_o, 4'hF);
    rst_n = 1'b1;
    tick(4);

    // default source, full frame
    check1("idle_sel_default", sel_o, 2'd3);
    start_frame(3);
    wait_done(1'b1, 1'b0, 3);
    check1("t1_queue_empty", exp_q.size(), 0);

    // source 1 request
    mode_i = 3'b010;
    tick(4);
    start_frame(1);
    wait_done(1'b1, 1'b0, 1);
    check1("t2_queue_empty", exp_q.size(), 0);

    // request change mid-frame takes effect only on the next frame
    mode_i = 3'b001;
    tick(4);
    start_frame(0);
    wait_beats(3);
    mode_i = 3'b100;
    push_frame(2);
    wait_done(1'b0, 1'b0, 0);
    tick(1);
    check1("b2b_busy", busy_o, 1'b1);
    check1("b2b_sel", sel_o, 2'd2);
    wait_done(1'b1, 1'b0, 2);
    check1("t3_queue_empty", exp_q.size(), 0);

    // packer back-pressure toggling every cycle
    tick(2);
    start_frame(2);
    wait_done(1'b1, 1'b1, 2);
    check1("t4_queue_empty", exp_q.size(), 0);

    // chorded buttons fall back to the default source
    mode_i = 3'b011;
    tick(4);
    check1("chord_sel", sel_o, 2'd3);
    start_frame(3);
    wait_done(1'b1, 1'b0, 3);
    check1("t5_queue_empty", exp_q.size(), 0);

    // reset in the middle of a frame abandons it
    mode_i = 3'b001;
    tick(4);
    start_frame(0);
    wait_beats(5);
    rst_n   = 1'b0;
    valid_i = '0;
    exp_q.delete();
    #1;
    check1("midrst_busy", busy_o, 1'b0);
    check1("midrst_sel", sel_o, 2'd3);
    check1("midrst_done", frame_done_o, 1'b0);
    tick(2);
    rst_n = 1'b1;
    tick(4);
    check1("post_rst_sel", sel_o, 2'd0);
    start_frame(0);
    wait_done(1'b1, 1'b0, 0);
    check1("t6_queue_empty", exp_q.size(), 0);

    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/frame_stream_ctrl.md
Name: frame_stream_ctrl

Overview:
Frame-aware output scheduler between the vision datapath taps (unpacked, Gx, Gy, magnitude) and the output packer. It takes a mode request from the board buttons, switches the selected source only at frame boundaries, and counts pixels and lines so each UART return frame holds exactly one full image from one source. Unselected taps are drained so the shared Sobel/magnitude pipeline never stalls on a tap that is not being output.

Parameters:
num_src_p, 4, number of source streams; index 0 is unpacked, 1 is Gx, 2 is Gy, 3 is magnitude.
width_p, 1, pixel width per source beat.
linewidth_px_p, 320, pixels per line; must be >= 2.
lines_p, 240, lines per frame; must be >= 1.
default_src_p, 3, source used when the mode request is not one-hot.

Ports:
clk_i  in  1  single clock.
reset_i  in  1  asynchronous, active-low reset.
mode_i  in  num_src_p-1  raw button levels, one-hot request for sources 0..num_src_p-2.
valid_i  in  num_src_p  per-source valid.
data_i  in  num_src_p*width_p  per-source pixel; source k occupies bits [k*width_p +: width_p].
ready_o  out  num_src_p  per-source ready.
valid_o  out  1  to packer.
data_o  out  width_p  to packer.
ready_i  in  1  from packer.
sel_o  out  $clog2(num_src_p)  currently latched source.
busy_o  out  1  high while a frame is in progress.
frame_done_o  out  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset (reset_i low, asynchronous): state IDLE, sel_o=default_src_p, col=0, row=0, sync flops=0, frame_done_o=0, busy_o=0.
- Mode sync: mode_i passes through a 2-flop synchronizer. Decode: exactly one bit k set selects k; any other pattern selects default_src_p.
- IDLE:
  - The decoded synchronized mode loads into sel every cycle.
  - valid_o=0.
  - ready_o is all ones, so every source is drained.
  - Move to STREAM when valid_i[decoded] is 1. Sel is frozen from that edge. The beat that triggers the move is not consumed in IDLE.
- STREAM:
  - valid_o=valid_i[sel], data_o=data_i[sel], ready_o[sel]=ready_i. These are combinational, with zero latency.
  - ready_o for every other source is 1 (discard).
  - busy_o=1.
  - A beat is accepted when valid_o && ready_i. Each accepted beat increments col.
  - At col==linewidth_px_p-1, col wraps to 0 and row increments.
  - At row==lines_p-1 && col==linewidth_px_p-1 (last beat accepted): col=0, row=0, frame_done_o=1 on the next cycle, return to IDLE.
- Mode changes during STREAM are ignored until IDLE; no mid-frame switch ever occurs.
- valid_o must not depend on ready_i. A source's data must not be discarded while that source is selected in STREAM.
- Back-to-back frames: IDLE lasts at least 1 cycle. Peak throughput is 1 beat/cycle inside a frame.
- Reset mid-frame: counters and state clear immediately. The partial frame is abandoned with no frame_done_o pulse.
- Counter widths are $clog2(linewidth_px_p) and $clog2(lines_p), with no overflow past the terminal counts.

Decomposition:
- Shared package (vision_pkg): source index constants SRC_UNPACK=0, SRC_GX=1, SRC_GY=2, SRC_MAG=3; the ctrl_state_e enum {IDLE, STREAM}; IMAGE_W/IMAGE_H constants.
- One sub-module: frame_counter, holding the col/row counters with wrap and a last-beat flag, parameterized by linewidth_px_p and lines_p.
- The synchronizer and decode stay inline.

Test Plan:
- Reset, W=4, H=2, mode_i=000, all sources valid, ready_i=1: sel_o=3; exactly 8 beats from data_i[3] appear on data_o; frame_done_o pulses once, the cycle after beat 8; busy_o drops.
- mode_i=010, stable for 3+ cycles before the frame starts: sel_o=1, and output matches the source-1 pattern 1,0,1,1,0,0,1,0.
- mode_i switches 001→100 after beat 3 of a frame: the remaining 5 beats still come from source 0; the next frame uses source 2.
- ready_i toggles 1,0,1,0 while valid stays high: the beat count reaches 8 only on accepted beats; data_o is held stable while stalled; unselected ready_o stays 1 throughout.
- mode_i=011 (not one-hot): sel_o=default_src_p=3.
- Reset asserted after beat 5, then released: no frame_done_o; the next frame streams a full 8 beats starting at col=0, row=0.
